// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding, CRC polynomial and word-count helper for the tile config loader.
package cfg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} cfg_state_t;
    localparam logic [7:0] CRC_POLY = 8'h07;
    function automatic int cfg_words(input int v, input int h, input int w);
        return (v * h + v + w - 1) / w;
    endfunction
endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8: CRC-8 (poly 0x07, init 0) folding one W-bit word per enabled cycle, LSB first.
module cfg_crc8
    import cfg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [7:0]   o_crc
);
    logic [7:0] w_next;
    // shift every bit of the word through the CRC register, din[0] first
    always_comb begin
        w_next = o_crc;
        for (int i = 0; i < W; i++)
            w_next = {w_next[6:0], 1'b0} ^ ((w_next[7] ^ i_data[i]) ? CRC_POLY : 8'h00);
    end
    // running CRC, restarted whenever the loader is idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) o_crc <= 8'h00;
        else if (i_en) o_crc <= w_next;
    end
endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: assembles a routing-tile bitstream from W-bit words and commits it atomically.
// Optional CRC-8 trailer check enabled by defining CFG_LOADER_CRC_EN.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int V = 4,
    parameter int H = 4,
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic [W-1:0]   i_din,
    input  logic           i_din_valid,
    output logic           o_din_ready,
    output logic [V*H-1:0] o_x_prog,
    output logic [V-1:0]   o_y_prog,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err
);
    localparam int N  = V * H + V;
    localparam int NW = cfg_words(V, H, W);
    localparam int CW = $clog2(NW + 1);

    cfg_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_shadow;
    logic [N-1:0]  w_shadow_next;
    logic          w_last;

    assign o_din_ready = (r_state == LOAD) || (r_state == CHECK);
    assign o_busy      = r_state != IDLE;
    assign w_last      = r_cnt == CW'(NW - 1);

    // drop the incoming word into its slot; padding bits past N have no home and vanish
    always_comb begin
        w_shadow_next = r_shadow;
        for (int j = 0; j < N; j++)
            if (j / W == int'(r_cnt)) w_shadow_next[j] = i_din[j % W];
    end

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] w_crc;
    logic [7:0] w_crc_in;
    // expected CRC lives in the low 8 bits of the trailer word
    always_comb begin
        w_crc_in = 8'h00;
        for (int i = 0; i < W && i < 8; i++) w_crc_in[i] = i_din[i];
    end
    cfg_crc8 #(.W(W)) u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (r_state == IDLE),
        .i_en    (r_state == LOAD && i_din_valid && !i_abort),
        .i_data  (i_din),
        .o_crc   (w_crc)
    );
`else
    assign o_err = 1'b0;
`endif

    // load sequencer: fabric outputs only ever change in COMMIT, so they never show partial data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            o_x_prog <= '0;
            o_y_prog <= '0;
            o_done   <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            o_err    <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start && !i_abort) begin
                    r_state <= LOAD;
                    r_cnt   <= '0;
`ifdef CFG_LOADER_CRC_EN
                    o_err   <= 1'b0;
`endif
                end
                LOAD: if (i_abort) r_state <= IDLE;
                else if (i_din_valid) begin
                    r_shadow <= w_shadow_next;
                    r_cnt    <= r_cnt + 1'b1;
`ifdef CFG_LOADER_CRC_EN
                    if (w_last) r_state <= CHECK;
`else
                    if (w_last) r_state <= COMMIT;
`endif
                end
`ifdef CFG_LOADER_CRC_EN
                CHECK: if (i_abort) r_state <= IDLE;
                else if (i_din_valid) begin
                    if (w_crc_in == w_crc) r_state <= COMMIT;
                    else begin
                        o_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                COMMIT: begin
                    o_x_prog <= r_shadow[V*H-1:0];
                    o_y_prog <= r_shadow[N-1:V*H];
                    o_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed table-driven bench for cfg_loader (V=4, H=4, W=8); CRC cases under CFG_LOADER_CRC_EN.
module tb_cfg_loader;
    localparam int V = 4;
    localparam int H = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           din_ready;
    logic [V*H-1:0] x_prog;
    logic [V-1:0]   y_prog;
    logic           busy;
    logic           done;
    logic           err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0;

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        int          gap;
        logic [15:0] x;
        logic [3:0]  y;
    } vec_t;
    vec_t vecs[6];

    cfg_loader #(.V(V), .H(H), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_din       (din),
        .i_din_valid (din_valid),
        .o_din_ready (din_ready),
        .o_x_prog    (x_prog),
        .o_y_prog    (y_prog),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [7:0] crc3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return crc_upd(crc_upd(crc_upd(8'h00, a), b), c);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input int gap);
        repeat (gap) tick;
        chk("din_ready_in_load", din_ready, 1);
        din = w;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
    endtask

    task automatic load(input vec_t v, input logic [15:0] prev_x);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        send(v.w0, v.gap);
        send(v.w1, v.gap);
        chk("x_hold_mid_load", x_prog, prev_x);
        send(v.w2, v.gap);
`ifdef CFG_LOADER_CRC_EN
        send(crc3(v.w0, v.w1, v.w2), v.gap);
`endif
        chk("x_hold_in_commit", x_prog, prev_x);
        chk("ready_low_commit", din_ready, 0);
        chk("done_low_commit", done, 0);
        d0 = done_cnt;
        tick;
        chk("x_prog", x_prog, v.x);
        chk("y_prog", y_prog, v.y);
        chk("done_pulse", done, 1);
        chk("busy_after_commit", busy, 0);
        tick;
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 0, 16'h3CA5, 4'hF};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 1, 16'hFFFF, 4'hF};
        vecs[2] = '{8'hA5, 8'h3C, 8'h0F, 4, 16'h3CA5, 4'hF};
        vecs[3] = '{8'h12, 8'h34, 8'hF6, 2, 16'h3412, 4'h6};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 0, 16'h0000, 4'h0};
        vecs[5] = '{8'h01, 8'h80, 8'h10, 3, 16'h8001, 4'h0};

        repeat (2) tick;
        rst_n = 1'b1;
        repeat (5) tick;
        chk("rst_x", x_prog, 0);
        chk("rst_y", y_prog, 0);
        chk("rst_ready", din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 6; i++) load(vecs[i], i == 0 ? 16'h0000 : vecs[i-1].x);
        load(vecs[0], 16'h8001);

        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        send(8'hFF, 0);
        send(8'hFF, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", din_ready, 0);
        chk("abort_x", x_prog, 16'h3CA5);
        chk("abort_y", y_prog, 4'hF);
        repeat (3) tick;
        chk("abort_no_done", done_cnt - d0, 0);

        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", busy, 0);

        start = 1'b1;
        tick;
        start = 1'b0;
        send(8'h12, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_ignored_busy", busy, 1);
        send(8'h34, 0);
        send(8'hF6, 0);
`ifdef CFG_LOADER_CRC_EN
        send(crc3(8'h12, 8'h34, 8'hF6), 0);
`endif
        tick;
        chk("start_ignored_x", x_prog, 16'h3412);
        chk("start_ignored_y", y_prog, 4'h6);
        tick;

        start = 1'b1;
        tick;
        start = 1'b0;
        send(8'hA5, 0);
        send(8'h3C, 0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_x", x_prog, 0);
        chk("midrst_y", y_prog, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", din_ready, 0);
        chk("midrst_done", done, 0);
        load(vecs[0], 16'h0000);

`ifdef CFG_LOADER_CRC_EN
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'hF6, 0);
        send(crc3(8'h12, 8'h34, 8'hF6) ^ 8'h01, 0);
        chk("crc_err", err, 1);
        chk("crc_err_busy", busy, 0);
        repeat (2) tick;
        chk("crc_err_sticky", err, 1);
        chk("crc_err_x", x_prog, 16'h3CA5);
        chk("crc_err_no_done", done_cnt - d0, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("crc_err_cleared", err, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
